// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion,
// depth derivation and the write-side flag bundle. Used by both FIFO sides.
package fifo_pkg;

  // Widest pointer the conversion helpers support; callers zero-extend into
  // this width and size-cast the result back down to their own pointer width.
  localparam int unsigned PTR_MAX_W = 32;

  // Registered write-side status flags.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wflags_t;

  // FIFO depth for a pointer of ptr_w bits (one extra bit for wrap detection).
  function automatic int unsigned fifo_depth(input int unsigned ptr_w);
    return 32'd1 << (ptr_w - 32'd1);
  endfunction

  // Binary to reflected Gray code. Zero-extended inputs convert correctly
  // because the upper zero bits contribute nothing to the XOR.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 32'd1) ^ b;
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray
  // bits at or above its position.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wgray_cntr.sv
// Write-side binary/Gray pointer pair. Holds the binary counter and the
// registered Gray pointer that crosses into the read domain, and exposes the
// next-state values so the flag logic can look one write ahead.
module fifo_wgray_cntr
  import fifo_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         wen,
  output logic [n-2:0] waddr,
  output logic [n-1:0] wbnext,
  output logic [n-1:0] wgnext,
  output logic [n-1:0] wptr
);

  logic [n-1:0] wbin_r;
  logic [n-1:0] wptr_r;
  logic [n-1:0] wbnext_s;
  logic [n-1:0] wgnext_s;

  // Next binary pointer advances only on an accepted write; Gray follows it.
  always_comb begin
    wbnext_s = wbin_r + {{(n-1){1'b0}}, wen};
    wgnext_s = n'(bin2gray(PTR_MAX_W'(wbnext_s)));
  end

  // Binary and Gray pointers update together so wptr moves one bit per write.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_r <= {n{1'b0}};
      wptr_r <= {n{1'b0}};
    end else begin
      wbin_r <= wbnext_s;
      wptr_r <= wgnext_s;
    end
  end

  assign waddr  = wbin_r[n-2:0];
  assign wbnext = wbnext_s;
  assign wgnext = wgnext_s;
  assign wptr   = wptr_r;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status block of an asynchronous FIFO. Generates the
// RAM write enable/address, the Gray write pointer for the read domain, and
// registered full / almost-full / sticky overflow flags against the
// synchronised read pointer. Requires n >= 3.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned n         = 4,
  parameter int unsigned AF_THRESH = 2
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         winc,
  input  logic [n-1:0] wq2_rptr,
  output logic [n-1:0] wptr,
  output logic [n-2:0] waddr,
  output logic         wen,
  output logic         wfull,
  output logic         walmost_full,
  output logic         woverflow
);

  localparam int unsigned DEPTH = fifo_depth(n);

  logic [n-1:0] wbnext_s;
  logic [n-1:0] wgnext_s;
  logic [n-1:0] rbin_s;
  logic [n-1:0] used_s;
  logic [n:0]   free_s;
  logic         full_match_s;
  logic         af_match_s;
  logic         wen_s;
  wflags_t      flags_r;
  wflags_t      flags_next_s;

  // A write is accepted in the same cycle it is requested unless already full.
  always_comb begin
    wen_s = winc & ~flags_r.full;
  end

  fifo_wgray_cntr #(
    .n(n)
  ) u_wgray_cntr (
    .wclk   (wclk),
    .wrst   (wrst),
    .wen    (wen_s),
    .waddr  (waddr),
    .wbnext (wbnext_s),
    .wgnext (wgnext_s),
    .wptr   (wptr)
  );

  // Occupancy after this cycle's write, kept non-negative by working modulo
  // 2**n before widening; full is the classic Gray compare with the top two
  // bits of the read pointer inverted.
  always_comb begin
    rbin_s       = n'(gray2bin(PTR_MAX_W'(wq2_rptr)));
    used_s       = wbnext_s - rbin_s;
    free_s       = (n+1)'(DEPTH) - {1'b0, used_s};
    full_match_s = (wgnext_s == {~wq2_rptr[n-1:n-2], wq2_rptr[n-3:0]});
    af_match_s   = (free_s <= (n+1)'(AF_THRESH));
  end

  // Next flag values; overflow latches any write attempt made while full.
  always_comb begin
    flags_next_s.full        = full_match_s;
    flags_next_s.almost_full = af_match_s;
    flags_next_s.overflow    = flags_r.overflow | (winc & flags_r.full);
  end

  // Flags are registered; release follows the read pointer by one clock.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      flags_r.full        <= 1'b0;
      flags_r.almost_full <= 1'b0;
      flags_r.overflow    <= 1'b0;
    end else begin
      flags_r <= flags_next_s;
    end
  end

  assign wen          = wen_s;
  assign wfull        = flags_r.full;
  assign walmost_full = flags_r.almost_full;
  assign woverflow    = flags_r.overflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (n=4, AF_THRESH=2). The reference
// model tracks unbounded write/read counts and derives occupancy directly.
module tb_fifo_wptr_full;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 2;
  localparam int MOD   = 16;

  logic         wclk = 1'b0;
  logic         wrst;
  logic         winc;
  logic [N-1:0] wq2_rptr;
  logic [N-1:0] wptr;
  logic [N-2:0] waddr;
  logic         wen;
  logic         wfull;
  logic         walmost_full;
  logic         woverflow;

  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int   m_wr;
  int   m_rd;
  logic m_full;
  logic m_af;
  logic m_ovf;
  logic cur_winc;

  fifo_wptr_full #(.n(N), .AF_THRESH(AF)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [N-1:0] to_gray(input int v);
    logic [N-1:0] b;
    b = N'(v % MOD);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; cur_winc = 1'b0;
  endtask

  // set inputs just after the falling edge, let combinational outputs settle
  task automatic drive(input logic w, input int rd);
    @(negedge wclk);
    cur_winc = w; winc = w; m_rd = rd; wq2_rptr = to_gray(rd);
    #1;
  endtask

  // rising edge, then advance the model from occupancy arithmetic
  task automatic tick();
    int occ;
    @(posedge wclk);
    if (cur_winc && m_full) m_ovf = 1'b1;
    if (cur_winc && !m_full) m_wr++;
    occ    = m_wr - m_rd;
    m_full = (occ == DEPTH);
    m_af   = ((DEPTH - occ) <= AF);
    #1;
  endtask

  task automatic assert_reset();
    #2;
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 0);
      n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL fill_wen[%0d]: got %b want 1", i, wen); end
      n_tests++; if (waddr !== 3'(i)) begin n_fail++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
      tick();
      if (i == 5) begin
        n_tests++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_at6: got %b want 1", walmost_full); end
        n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL fill_full_at6: got %b want 0", wfull); end
      end
      if (i < 5) begin
        n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_early[%0d]: got %b want 0", i, walmost_full); end
      end
    end
    n_tests++; if (wptr !== 4'b1100) begin n_fail++; $display("FAIL fill_wptr: got %b want 1100", wptr); end
    n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", wfull); end
    n_tests++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af: got %b want 1", walmost_full); end
    n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b want 0", woverflow); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 0);
    n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen: got %b want 0", wen); end
    tick();
    n_tests++; if (wptr !== 4'b1100) begin n_fail++; $display("FAIL ovf_wptr: got %b want 1100", wptr); end
    n_tests++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", woverflow); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0);
      tick();
      n_tests++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, woverflow); end
    end
  endtask

  task automatic test_drop_and_release();
    drive(1'b1, 1);
    n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL drop_wen: got %b want 0", wen); end
    tick();
    n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL drop_full_clear: got %b want 0", wfull); end
    n_tests++; if (wptr !== 4'b1100) begin n_fail++; $display("FAIL drop_wptr: got %b want 1100", wptr); end
    drive(1'b1, 1);
    n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL drop_next_wen: got %b want 1", wen); end
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL drop_next_waddr: got %0d want 0", waddr); end
    tick();
    n_tests++; if (wptr !== 4'b1101) begin n_fail++; $display("FAIL drop_next_wptr: got %b want 1101", wptr); end
    n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL drop_refull: got %b want 1", wfull); end
  endtask

  // reset arrives mid-cycle while full with overflow set
  task automatic test_reset();
    assert_reset();
    n_tests++; if (wptr !== 4'b0000) begin n_fail++; $display("FAIL rst_wptr: got %b want 0000", wptr); end
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL rst_waddr: got %0d want 0", waddr); end
    n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", wfull); end
    n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af: got %b want 0", walmost_full); end
    n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", woverflow); end
    @(posedge wclk); #1;
    n_tests++; if (wptr !== 4'b0000) begin n_fail++; $display("FAIL rst_hold_wptr: got %b want 0000", wptr); end
    release_reset();
  endtask

  task automatic test_tracking();
    int rd;
    for (int i = 0; i < 20; i++) begin
      rd = (m_wr >= 2) ? m_wr - 2 : 0;
      drive(1'b1, rd);
      n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL trk_wen[%0d]: got %b want 1", i, wen); end
      n_tests++; if (waddr !== 3'(m_wr % DEPTH)) begin n_fail++; $display("FAIL trk_waddr[%0d]: got %0d want %0d", i, waddr, m_wr % DEPTH); end
      tick();
      n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL trk_full[%0d]: got %b want 0", i, wfull); end
      n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL trk_af[%0d]: got %b want 0", i, walmost_full); end
      n_tests++; if (wptr !== to_gray(i + 1)) begin n_fail++; $display("FAIL trk_wptr[%0d]: got %b want %b", i, wptr, to_gray(i + 1)); end
    end
    n_tests++; if (wptr !== 4'b0110) begin n_fail++; $display("FAIL trk_wrap_wptr: got %b want 0110", wptr); end
  endtask

  task automatic test_reset_mid_burst();
    assert_reset();
    release_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0);
      tick();
    end
    n_tests++; if (wptr !== 4'b0111) begin n_fail++; $display("FAIL mid_pre_wptr: got %b want 0111", wptr); end
    assert_reset();
    n_tests++; if (wptr !== 4'b0000) begin n_fail++; $display("FAIL mid_wptr: got %b want 0000", wptr); end
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL mid_waddr: got %0d want 0", waddr); end
    n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL mid_wen: got %b want 0", wen); end
    n_tests++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b want 000", {wfull, walmost_full, woverflow}); end
    release_reset();
    drive(1'b1, 0);
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL mid_first_waddr: got %0d want 0", waddr); end
    n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL mid_first_wen: got %b want 1", wen); end
    tick();
    n_tests++; if (wptr !== 4'b0001) begin n_fail++; $display("FAIL mid_first_wptr: got %b want 0001", wptr); end
  endtask

  task automatic test_random();
    logic w;
    int   rd;
    assert_reset();
    release_reset();
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 65);
      rd = m_rd;
      if (m_rd < m_wr && $urandom_range(0, 99) < 50) rd = m_rd + int'($urandom_range(1, m_wr - m_rd));
      drive(w, rd);
      n_tests++; if (wen !== (w & ~m_full)) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, wen, w & ~m_full); end
      n_tests++; if (waddr !== 3'(m_wr % DEPTH)) begin n_fail++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", i, waddr, m_wr % DEPTH); end
      tick();
      n_tests++; if (wfull !== m_full) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, wfull, m_full); end
      n_tests++; if (walmost_full !== m_af) begin n_fail++; $display("FAIL rnd_af[%0d]: got %b want %b", i, walmost_full, m_af); end
      n_tests++; if (woverflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, woverflow, m_ovf); end
      n_tests++; if (wptr !== to_gray(m_wr)) begin n_fail++; $display("FAIL rnd_wptr[%0d]: got %b want %b", i, wptr, to_gray(m_wr)); end
    end
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;
    model_reset();
    repeat (2) @(posedge wclk);
    release_reset();
    test_fill();
    test_overflow();
    test_drop_and_release();
    test_reset();
    test_tracking();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 Parameter n, default 4: pointer width in bits; address width is n-1; FIFO depth is DEPTH = 2**(n-1).
REQ-002 Parameter AF_THRESH, default 2: walmost_full asserts when free slots are at or below this value; legal range is 1..DEPTH-1.
REQ-003 Port wclk, input, 1 bit: write-domain clock.
REQ-004 Port wrst, input, 1 bit: reset, asynchronous, active-high; one clock, and reset is asynchronous and active-high.
REQ-005 Port winc, input, 1 bit: write request from the producer.
REQ-006 Port wq2_rptr, input, n bits: Gray read pointer, already double-synchronised into wclk.
REQ-007 Port wptr, output, n bits: registered Gray write pointer, sent to the read-domain synchroniser.
REQ-008 Port waddr, output, n-1 bits: binary write address to the storage RAM.
REQ-009 Port wen, output, 1 bit: RAM write enable.
REQ-010 Port wfull, output, 1 bit: registered full flag.
REQ-011 Port walmost_full, output, 1 bit: registered almost-full flag.
REQ-012 Port woverflow, output, 1 bit: sticky error, set when a write is attempted while full.

Function
REQ-013 wen SHALL equal winc & ~wfull, combinationally; the write is accepted on the same wclk edge.
REQ-014 Internal binary counter wbin (n bits) SHALL increment by 1 on each edge where wen=1; it wraps modulo 2**n.
REQ-015 waddr SHALL equal wbin[n-2:0], the current-cycle binary address; no added latency.
REQ-016 wbnext SHALL equal wbin + wen; wgnext SHALL be the Gray encoding of wbnext, i.e. (wbnext>>1)^wbnext.
REQ-017 wptr SHALL be wgnext registered on wclk, so wptr changes by exactly one bit per accepted write.
REQ-018 wfull SHALL register the result of wgnext == {~wq2_rptr[n-1:n-2], wq2_rptr[n-3:0]}; it asserts on the edge of the write that fills slot DEPTH.
REQ-019 Free slots SHALL be computed as DEPTH - ((wbnext - gray2bin(wq2_rptr)) mod 2**n), in n+1-bit unsigned arithmetic with no negative intermediates.
REQ-020 walmost_full SHALL register (free slots <= AF_THRESH); it is always 1 whenever wfull is 1.
REQ-021 Deassertion of wfull and walmost_full SHALL follow wq2_rptr advance with one wclk of registration latency and no extra filtering (pessimistic, never late to assert).
REQ-022 woverflow SHALL set on any edge where winc=1 and wfull=1, and SHALL stay set until reset.
REQ-023 Pointer wrap-around, where wbin goes from 2**n-1 to 0, SHALL neither glitch nor falsely assert wfull.
REQ-024 Simultaneous write-while-full and read-pointer advance in the same cycle: the write SHALL be dropped (wen=0), and wfull SHALL clear on the next edge.

Reset
REQ-025 While wrst=1, regardless of wclk: wbin=0, wptr=0, wfull=0, walmost_full=0, woverflow=0.
REQ-026 Assertion of reset mid-stream SHALL discard all pointer state immediately; the first write after release SHALL use waddr=0.
REQ-027 Release of wrst SHALL be synchronous to wclk at system level; the block itself adds no reset synchroniser.

Structure
REQ-028 The shared fifo package SHALL hold the bin2gray and gray2bin functions and the DEPTH derivation, reused by the read side.
REQ-029 One sub-module, fifo_wgray_cntr, SHALL contain wbin, wbnext, wgnext and the wptr register; fifo_wptr_full contains the flag logic and the overflow sticky bit.

Verification
REQ-030 Reset then hold wq2_rptr=0 with n=4, and write 8 times -> waddr steps 0..7; wptr after write 8 = 4'b1100; wfull=1 after the 8th edge.
REQ-031 While full with wq2_rptr=0, set winc=1 -> wen=0, wptr is unchanged, woverflow=1 and stays 1 until wrst.
REQ-032 Run 20 write/read cycles with the reader tracking (wq2_rptr set to the Gray value of the write count minus 2) -> wfull is never set, walmost_full is never set, and wrap past 15 is clean.
REQ-033 With AF_THRESH=2 and wq2_rptr=0, write 6 times -> walmost_full=1 after the 6th edge and wfull=0; after the 8th write both flags are 1.
REQ-034 While full, advance wq2_rptr to Gray(1) with winc=1 in the same cycle -> the write is dropped, wfull=0 on the next edge, and the following write is accepted at waddr=0.
REQ-035 Assert wrst mid-burst after 5 writes -> all outputs are 0 asynchronously; after release, the first write uses waddr=0.
